// File: rtl/mc_req_queue_pkg.sv
// Shared memory-controller types: request op encoding, decoded request payload and
// DIMM address field positions used by the request queue and the scheduler.
package mc_req_queue_pkg;

    localparam int unsigned ADDR_W  = 36;
    localparam int unsigned Q_DEPTH = 16;

    localparam int unsigned ROW_LSB    = 18;
    localparam int unsigned ROW_W      = 16;
    localparam int unsigned COL_HI_LSB = 12;
    localparam int unsigned COL_HI_W   = 6;
    localparam int unsigned COL_LO_LSB = 2;
    localparam int unsigned COL_LO_W   = 4;
    localparam int unsigned COL_W      = COL_HI_W + COL_LO_W;
    localparam int unsigned BANK_LSB   = 10;
    localparam int unsigned BANK_W     = 2;
    localparam int unsigned BG_LSB     = 7;
    localparam int unsigned BG_W       = 3;
    localparam int unsigned CHAN_BIT   = 6;

    typedef enum logic [1:0] {
        OP_RD  = 2'd0,
        OP_WR  = 2'd1,
        OP_IF  = 2'd2,
        OP_ILL = 2'd3
    } op_e;

    typedef struct packed {
        op_e                op;
        logic [ROW_W-1:0]   row;
        logic [COL_W-1:0]   col;
        logic [BANK_W-1:0]  bank;
        logic [BG_W-1:0]    bg;
        logic               chan;
    } mc_req_t;

endpackage

// File: rtl/mc_req_queue_addr_decode.sv
// Combinational split of a 36-bit physical address plus op into the DIMM request
// fields (row, column, bank, bank group, channel).
module mc_req_queue_addr_decode
    import mc_req_queue_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        op,
    output mc_req_t           req
);

    // Address bits above the row and the byte offset within a burst are not mapped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[ADDR_W-1:ROW_LSB+ROW_W], addr[COL_LO_LSB-1:0]};

    always_comb begin
        req      = '0;
        req.op   = op_e'(op);
        req.row  = addr[ROW_LSB +: ROW_W];
        req.col  = {addr[COL_HI_LSB +: COL_HI_W], addr[COL_LO_LSB +: COL_LO_W]};
        req.bank = addr[BANK_LSB +: BANK_W];
        req.bg   = addr[BG_LSB +: BG_W];
        req.chan = addr[CHAN_BIT];
    end

endmodule

// File: rtl/mc_req_queue.sv
// In-order DDR5 controller request queue with enqueue timestamps and head age.
// Optional statistics counters are built when MC_REQ_Q_STATS_EN is defined.
module mc_req_queue
    import mc_req_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = Q_DEPTH,
    parameter  int unsigned TS_W  = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [ADDR_W-1:0]  in_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_op,
    output logic [ROW_W-1:0]   out_row,
    output logic [COL_W-1:0]   out_col,
    output logic [BANK_W-1:0]  out_bank,
    output logic [BG_W-1:0]    out_bg,
    output logic               out_chan,
    output logic [TS_W-1:0]    out_age,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               err_illegal
`ifdef MC_REQ_Q_STATS_EN
    ,
    output logic [31:0]        stat_accepts,
    output logic [31:0]        stat_full_cycles,
    output logic [CNT_W-1:0]   stat_max_count
`endif
);

    mc_req_t            mem    [DEPTH];
    logic [TS_W-1:0]    mem_ts [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_next;
    logic [CNT_W-1:0]   cnt_q, cnt_after_pop, cnt_next;
    logic [TS_W-1:0]    ts_q, ts_next;
    logic               in_ready_q, full_q, out_valid_q, err_q;
    mc_req_t            head_q, head_next, dec;
    logic [TS_W-1:0]    head_ts_next, age_q, age_next;
    logic               fire, push, pop, illegal, valid_next;

    mc_req_queue_addr_decode u_decode (
        .addr (in_addr),
        .op   (in_op),
        .req  (dec)
    );

    // Handshake qualification, occupancy and pointer bookkeeping.
    always_comb begin
        fire          = in_valid && in_ready_q;
        illegal       = fire && (op_e'(in_op) == OP_ILL);
        push          = fire && !illegal;
        pop           = out_valid_q && out_ready;
        cnt_after_pop = cnt_q - CNT_W'(pop);
        cnt_next      = cnt_after_pop + CNT_W'(push);
        rd_ptr_next   = rd_ptr_q + PTR_W'(pop);
        ts_next       = ts_q + TS_W'(1);
        valid_next    = (cnt_next != '0);
    end

    // Next head: the incoming request when it lands in an otherwise empty queue.
    always_comb begin
        head_next    = '0;
        head_ts_next = '0;
        age_next     = '0;
        if (valid_next) begin
            if (push && (cnt_after_pop == '0)) begin
                head_next    = dec;
                head_ts_next = ts_q;
            end else begin
                head_next    = mem[rd_ptr_next];
                head_ts_next = mem_ts[rd_ptr_next];
            end
            age_next = ts_next - head_ts_next;
        end
    end

    // Entry storage has no reset; the pointers and count define which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q]    <= dec;
            mem_ts[wr_ptr_q] <= ts_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ts_q        <= '0;
            in_ready_q  <= 1'b1;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            head_q      <= '0;
            age_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q    <= rd_ptr_next;
            cnt_q       <= cnt_next;
            ts_q        <= ts_next;
            in_ready_q  <= (cnt_next != CNT_W'(DEPTH));
            full_q      <= (cnt_next == CNT_W'(DEPTH));
            out_valid_q <= valid_next;
            err_q       <= illegal;
            head_q      <= head_next;
            age_q       <= age_next;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_op      = head_q.op;
    assign out_row     = head_q.row;
    assign out_col     = head_q.col;
    assign out_bank    = head_q.bank;
    assign out_bg      = head_q.bg;
    assign out_chan    = head_q.chan;
    assign out_age     = age_q;
    assign count       = cnt_q;
    assign full        = full_q;
    assign err_illegal = err_q;

`ifdef MC_REQ_Q_STATS_EN
    logic [31:0]      acc_q, fullc_q;
    logic [CNT_W-1:0] maxc_q;

    // Saturating activity counters and occupancy high-water mark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            fullc_q <= '0;
            maxc_q  <= '0;
        end else begin
            if (push && (acc_q != '1))
                acc_q <= acc_q + 32'd1;
            if (in_valid && full_q && (fullc_q != '1))
                fullc_q <= fullc_q + 32'd1;
            if (cnt_next > maxc_q)
                maxc_q <= cnt_next;
        end
    end

    assign stat_accepts     = acc_q;
    assign stat_full_cycles = fullc_q;
    assign stat_max_count   = maxc_q;
`endif

endmodule

// File: tb/tb_mc_req_queue.sv
// Randomised and directed bench for mc_req_queue against a queue-based reference model;
// a second instance with a 5-bit timestamp exercises age across a timestamp wrap.
module tb_mc_req_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  in_op, out_op;
    logic [35:0] in_addr;
    logic [15:0] out_row;
    logic [9:0]  out_col;
    logic [1:0]  out_bank;
    logic [2:0]  out_bg;
    logic        out_chan;
    logic [31:0] out_age;
    logic [4:0]  count;
    logic        full, err_illegal;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [1:0]  w_in_op, w_out_op;
    logic [35:0] w_in_addr;
    logic [15:0] w_out_row;
    logic [9:0]  w_out_col;
    logic [1:0]  w_out_bank;
    logic [2:0]  w_out_bg;
    logic        w_out_chan;
    logic [4:0]  w_out_age;
    logic [4:0]  w_count;
    logic        w_full, w_err_illegal;

`ifdef MC_REQ_Q_STATS_EN
    logic [31:0] stat_accepts, stat_full_cycles, w_stat_accepts, w_stat_full_cycles;
    logic [4:0]  stat_max_count, w_stat_max_count;
`endif

    always #5 clk = ~clk;

    mc_req_queue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_row(out_row), .out_col(out_col), .out_bank(out_bank), .out_bg(out_bg),
        .out_chan(out_chan), .out_age(out_age), .count(count), .full(full),
        .err_illegal(err_illegal)
`ifdef MC_REQ_Q_STATS_EN
        , .stat_accepts(stat_accepts), .stat_full_cycles(stat_full_cycles),
        .stat_max_count(stat_max_count)
`endif
    );

    mc_req_queue #(.TS_W(5)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_op(w_in_op), .in_addr(w_in_addr),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_op(w_out_op),
        .out_row(w_out_row), .out_col(w_out_col), .out_bank(w_out_bank), .out_bg(w_out_bg),
        .out_chan(w_out_chan), .out_age(w_out_age), .count(w_count), .full(w_full),
        .err_illegal(w_err_illegal)
`ifdef MC_REQ_Q_STATS_EN
        , .stat_accepts(w_stat_accepts), .stat_full_cycles(w_stat_full_cycles),
        .stat_max_count(w_stat_max_count)
`endif
    );

    typedef struct {
        logic [1:0]  op;
        logic [35:0] addr;
        logic [31:0] ts;
    } ment_t;

    ment_t       mq[$];
    logic [31:0] m_ts;
    bit          m_err;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] rnd_addr();
        logic [35:0] a;
        a = {4'($urandom), 32'($urandom)};
        return a;
    endfunction

    // Expected outputs straight from the queue contents and the bit-field map.
    task automatic check_all();
        int          sz;
        logic [35:0] a;
        logic [1:0]  op;
        logic [31:0] age;
        sz  = mq.size();
        a   = '0;
        op  = '0;
        age = '0;
        if (sz > 0) begin
            a   = mq[0].addr;
            op  = mq[0].op;
            age = m_ts - mq[0].ts;
        end
        chk("count",       64'(count),       64'(sz));
        chk("full",        64'(full),        64'(sz == 16));
        chk("in_ready",    64'(in_ready),    64'(sz < 16));
        chk("out_valid",   64'(out_valid),   64'(sz > 0));
        chk("err_illegal", 64'(err_illegal), 64'(m_err));
        chk("out_op",      64'(out_op),      64'(op));
        chk("out_row",     64'(out_row),     64'(a[33:18]));
        chk("out_col",     64'(out_col),     64'({a[17:12], a[5:2]}));
        chk("out_bank",    64'(out_bank),    64'(a[11:10]));
        chk("out_bg",      64'(out_bg),      64'(a[9:7]));
        chk("out_chan",    64'(out_chan),    64'(a[6]));
        chk("out_age",     64'(out_age),     64'(age));
    endtask

    task automatic model_update(input bit v, input logic [1:0] op, input logic [35:0] addr,
                                input bit rdy);
        bit acc, pop;
        acc = v && (mq.size() < 16);
        pop = (mq.size() > 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (acc && op != 2'd3) mq.push_back('{op, addr, m_ts});
        m_err = acc && (op == 2'd3);
        m_ts  = m_ts + 32'd1;
    endtask

    // One clock: drive at negedge, model at posedge, compare at the next negedge.
    task automatic step(input bit v, input logic [1:0] op, input logic [35:0] addr,
                        input bit rdy);
        in_valid  = v;
        in_op     = op;
        in_addr   = addr;
        out_ready = rdy;
        @(posedge clk);
        model_update(v, op, addr, rdy);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 36'd0, rdy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_ts  = '0;
        m_err = 1'b0;
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_full",      64'(full),      64'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [1:0]  h_op;
    logic [35:0] h_addr;

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_op       = '0;
        in_addr     = '0;
        out_ready   = 1'b0;
        w_in_valid  = 1'b0;
        w_in_op     = '0;
        w_in_addr   = '0;
        w_out_ready = 1'b0;
        m_ts        = '0;
        m_err       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Age across a timestamp wrap on the 5-bit instance: enqueue at ts=29.
        idle(29, 1'b0);
        w_in_valid = 1'b1;
        w_in_addr  = 36'h0_00FC_0C80;
        idle(1, 1'b0);
        w_in_valid = 1'b0;
        chk("wrap_age1", 64'(w_out_age), 64'd1);
        idle(4, 1'b0);
        chk("wrap_age5",   64'(w_out_age),   64'd5);
        chk("wrap_valid",  64'(w_out_valid), 64'd1);
        chk("wrap_row",    64'(w_out_row),   64'h003F);
        w_out_ready = 1'b1;
        idle(1, 1'b0);
        w_out_ready = 1'b0;
        chk("wrap_popped", 64'(w_out_valid), 64'd0);
        chk("wrap_age0",   64'(w_out_age),   64'd0);

        // Decode and latency, then age 15 for an entry enqueued at ts=10.
        do_reset();
        idle(10, 1'b0);
        chk("pre_valid", 64'(out_valid), 64'd0);
        step(1'b1, 2'd0, 36'h0_00FC_0C80, 1'b0);
        chk("dec_valid", 64'(out_valid), 64'd1);
        chk("dec_row",   64'(out_row),   64'h003F);
        chk("dec_col",   64'(out_col),   64'd0);
        chk("dec_bank",  64'(out_bank),  64'd3);
        chk("dec_bg",    64'(out_bg),    64'd1);
        chk("dec_chan",  64'(out_chan),  64'd0);
        chk("dec_op",    64'(out_op),    64'd0);
        idle(14, 1'b0);
        chk("age15", 64'(out_age), 64'd15);
        idle(1, 1'b1);
        chk("age_pop_valid", 64'(out_valid), 64'd0);

        // Reset mid-traffic with seven entries held.
        for (int i = 0; i < 7; i++) step(1'b1, 2'($urandom_range(0, 2)), rnd_addr(), 1'b0);
        chk("pre_rst_count", 64'(count), 64'd7);
        do_reset();

        // Fill to full, hold off the 17th, pop once, then accept it.
        for (int i = 0; i < 16; i++) step(1'b1, 2'($urandom_range(0, 2)), rnd_addr(), 1'b0);
        chk("full_count", 64'(count),    64'd16);
        chk("full_flag",  64'(full),     64'd1);
        chk("full_ready", 64'(in_ready), 64'd0);
        h_op   = 2'd1;
        h_addr = rnd_addr();
        step(1'b1, h_op, h_addr, 1'b0);
        chk("held_count", 64'(count), 64'd16);
        step(1'b1, h_op, h_addr, 1'b1);
        chk("pop_full_count", 64'(count),    64'd15);
        chk("pop_full_ready", 64'(in_ready), 64'd1);
        step(1'b1, h_op, h_addr, 1'b0);
        chk("refill_count", 64'(count), 64'd16);
        idle(16, 1'b1);
        chk("drain_count", 64'(count), 64'd0);

        // Simultaneous enqueue and dequeue at count 5; rows 1..5 tag entries.
        for (int i = 1; i <= 5; i++) step(1'b1, 2'd0, 36'(i) << 18, 1'b0);
        chk("five_count", 64'(count),   64'd5);
        chk("five_head",  64'(out_row), 64'h0001);
        step(1'b1, 2'd1, 36'd6 << 18, 1'b1);
        chk("swap_count", 64'(count),   64'd5);
        chk("swap_head",  64'(out_row), 64'h0002);

        // Illegal op: pulse only, no state change.
        step(1'b1, 2'd3, rnd_addr(), 1'b0);
        chk("ill_err",   64'(err_illegal), 64'd1);
        chk("ill_count", 64'(count),       64'd5);
        chk("ill_valid", 64'(out_valid),   64'd1);
        idle(1, 1'b0);
        chk("ill_err_clr", 64'(err_illegal), 64'd0);

        // Random traffic across a range of downstream pop rates.
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 600; i++)
                step($urandom_range(0, 99) < 70, 2'($urandom), rnd_addr(),
                     $urandom_range(0, 99) < (p * 30 + 10));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
